// File: rtl/sudoku_grid_store.sv
// Sudoku grid store: row-major handshake load, registered readback, and a sequential
// consistency checker that scans every row, column and box one cell per cycle.
module sudoku_grid_store #(
  parameter int unsigned BOX = 3,
  localparam int unsigned DIM = BOX * BOX,
  localparam int unsigned CELLS = DIM * DIM,
  localparam int unsigned CW = $clog2(DIM + 1),
  localparam int unsigned IW = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] in_value,
  output logic          in_ready,
  input  logic          clear,
  input  logic          chk_start,
  input  logic [IW-1:0] rd_row,
  input  logic [IW-1:0] rd_col,
  output logic [CW-1:0] rd_value,
  output logic          loaded,
  output logic          busy,
  output logic          chk_done,
  output logic          chk_ok,
  output logic          chk_full,
  output logic          bad_value
);

  localparam int unsigned SCAN = 3 * CELLS;
  localparam int unsigned SW = $clog2(SCAN);

  localparam logic [1:0] PassRow = 2'd0;
  localparam logic [1:0] PassCol = 2'd1;
  localparam logic [1:0] PassBox = 2'd2;

  typedef enum logic [1:0] {StLoad, StReady, StCheck, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic          loaded_q, loaded_d;
  logic          bad_q, bad_d;
  logic [1:0]    pass_q, pass_d;
  logic [IW-1:0] grp_q, grp_d, idx_q, idx_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DIM-1:0] seen_q, seen_d;
  logic          ok_run_q, ok_run_d;
  logic          full_run_q, full_run_d;
  logic          chk_ok_q, chk_ok_d;
  logic          chk_full_q, chk_full_d;
  logic [CW-1:0] rd_q, rd_next;

  logic [CW-1:0] cell_q [DIM][DIM];

  logic          xfer;
  logic          last_cell;
  logic [CW-1:0] wr_val;
  logic [IW-1:0] scan_r, scan_c;
  logic [CW-1:0] scan_v;
  logic [DIM-1:0] seen_base, dig_oh;
  logic          dup;
  logic          scan_last;

  assign xfer      = in_valid && (state_q == StLoad);
  assign last_cell = (row_q == IW'(DIM - 1)) && (col_q == IW'(DIM - 1));
  assign wr_val    = (in_value > CW'(DIM)) ? '0 : in_value;

  // Map (pass, group, index) to the cell visited this scan cycle.
  always_comb begin
    scan_r = '0;
    scan_c = '0;
    case (pass_q)
      PassRow: begin
        scan_r = grp_q;
        scan_c = idx_q;
      end
      PassCol: begin
        scan_r = idx_q;
        scan_c = grp_q;
      end
      PassBox: begin
        scan_r = IW'((grp_q / BOX) * BOX + idx_q / BOX);
        scan_c = IW'((grp_q % BOX) * BOX + idx_q % BOX);
      end
      default: begin
        scan_r = '0;
        scan_c = '0;
      end
    endcase
  end

  assign scan_v    = cell_q[scan_r][scan_c];
  assign seen_base = (idx_q == '0) ? '0 : seen_q;
  assign dig_oh    = (scan_v == '0) ? '0 : (DIM'(1) << (scan_v - CW'(1)));
  assign dup       = |(seen_base & dig_oh);
  assign scan_last = (scan_cnt_q == SW'(SCAN - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    loaded_d   = loaded_q;
    bad_d      = bad_q;
    pass_d     = pass_q;
    grp_d      = grp_q;
    idx_d      = idx_q;
    scan_cnt_d = scan_cnt_q;
    seen_d     = seen_q;
    ok_run_d   = ok_run_q;
    full_run_d = full_run_q;
    chk_ok_d   = chk_ok_q;
    chk_full_d = chk_full_q;

    case (state_q)
      StLoad: begin
        if (xfer) begin
          bad_d = bad_q | (in_value > CW'(DIM));
          if (last_cell) begin
            row_d    = '0;
            col_d    = '0;
            loaded_d = 1'b1;
            state_d  = StReady;
          end else if (col_q == IW'(DIM - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StReady: begin
        if (chk_start) begin
          state_d    = StCheck;
          pass_d     = PassRow;
          grp_d      = '0;
          idx_d      = '0;
          scan_cnt_d = '0;
          seen_d     = '0;
          ok_run_d   = 1'b1;
          full_run_d = 1'b1;
        end
      end
      StCheck: begin
        seen_d     = seen_base | dig_oh;
        ok_run_d   = ok_run_q & ~dup;
        if ((pass_q == PassRow) && (scan_v == '0)) begin
          full_run_d = 1'b0;
        end
        scan_cnt_d = scan_cnt_q + 1'b1;
        if (idx_q == IW'(DIM - 1)) begin
          idx_d = '0;
          if (grp_q == IW'(DIM - 1)) begin
            grp_d  = '0;
            pass_d = pass_q + 2'd1;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
        // Publish the result including the final cell's contribution.
        if (scan_last) begin
          state_d    = StDone;
          chk_ok_d   = ok_run_d;
          chk_full_d = full_run_d;
        end
      end
      StDone: begin
        state_d = StReady;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= StLoad;
      row_q      <= '0;
      col_q      <= '0;
      loaded_q   <= 1'b0;
      bad_q      <= 1'b0;
      pass_q     <= PassRow;
      grp_q      <= '0;
      idx_q      <= '0;
      scan_cnt_q <= '0;
      seen_q     <= '0;
      ok_run_q   <= 1'b1;
      full_run_q <= 1'b1;
      chk_ok_q   <= 1'b0;
      chk_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      loaded_q   <= loaded_d;
      bad_q      <= bad_d;
      pass_q     <= pass_d;
      grp_q      <= grp_d;
      idx_q      <= idx_d;
      scan_cnt_q <= scan_cnt_d;
      seen_q     <= seen_d;
      ok_run_q   <= ok_run_d;
      full_run_q <= full_run_d;
      chk_ok_q   <= chk_ok_d;
      chk_full_q <= chk_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned r = 0; r < DIM; r++) begin
        for (int unsigned c = 0; c < DIM; c++) begin
          cell_q[r][c] <= '0;
        end
      end
    end else if (xfer) begin
      cell_q[row_q][col_q] <= wr_val;
    end
  end

  assign rd_next = ((32'(rd_row) < DIM) && (32'(rd_col) < DIM)) ? cell_q[rd_row][rd_col] : '0;

  // Readback keeps running through clear; only rst forces it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_next;
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q == StCheck);
  assign chk_done  = (state_q == StDone);
  assign loaded    = loaded_q;
  assign bad_value = bad_q;
  assign chk_ok    = chk_ok_q;
  assign chk_full  = chk_full_q;
  assign rd_value  = rd_q;

endmodule
